// File: rtl/dac_ad5318_ctrl.sv
// dac_ad5318_ctrl: serial-port master and request arbiter for the 8-channel
// 10-bit AD5318 DAC. Per-channel code updates and raw 16-bit control words
// are arbitrated, framed and shifted out on SCLK/SYNC_b/DIN.
//
// Optional feature macro: DAC_AD5318_CTRL_LDAC_PULSE_EN
//   defined   : LDAC_b idles high and pulses low for LDAC_W cycles after a
//               batch of channel frames, so all channels update together.
//   undefined : LDAC_b is tied low (transparent update), LDAC_W is unused.
module dac_ad5318_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int SYNC_GAP  = 4,
  parameter int MSB_FIRST = 1,
  parameter int LDAC_W    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  ch_req,
  input  logic [79:0] ch_data,
  output logic [7:0]  ch_ack,
  input  logic        cfg_req,
  input  logic [15:0] cfg_word,
  output logic        cfg_ack,
  output logic        busy,
  output logic        SCLK,
  output logic        SYNC_b,
  output logic        DIN,
  output logic        LDAC_b
);

  localparam int HC_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int GC_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [HC_W-1:0] HC_RELOAD = HC_W'(CLK_DIV - 1);
  localparam logic [GC_W-1:0] GC_RELOAD = GC_W'(SYNC_GAP - 1);
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
  localparam int LC_W = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
  localparam logic [LC_W-1:0] LC_RELOAD = LC_W'(LDAC_W - 1);
`endif

  // Reject nonsensical timing parameters at elaboration.
  if (CLK_DIV < 1 || SYNC_GAP < 1 || LDAC_W < 1) begin : g_bad_params
    $error("dac_ad5318_ctrl: CLK_DIV, SYNC_GAP and LDAC_W must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
    S_GAP,
    S_LDAC
`else
    S_GAP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            sclk_q;
  logic [HC_W-1:0] hcnt_q;
  logic [3:0]      bcnt_q;
  logic [15:0]     sr_q;
  logic [GC_W-1:0] gcnt_q;
  logic [2:0]      ptr_q;
  logic            gnt_cfg_q;
  logic [2:0]      gnt_idx_q;
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
  logic            ldac_pend_q;
  logic [LC_W-1:0] lcnt_q;
`endif

  logic            arb_found;
  logic [2:0]      arb_idx;
  logic [15:0]     chan_frame;
  logic            half_end;
  logic            frame_end;

  // The shift register always shifts left; LSB-first frames are bit-reversed
  // once at capture so DIN is always taken from sr_q[15].
  function automatic logic [15:0] orient(input logic [15:0] w);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = (MSB_FIRST != 0) ? w[b] : w[15-b];
    return r;
  endfunction

  // Round-robin search over channel requests starting at the pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      if (!arb_found && ch_req[3'(ptr_q + 3'(k))]) begin
        arb_found = 1'b1;
        arb_idx   = 3'(ptr_q + 3'(k));
      end
    end
    chan_frame = {1'b0, arb_idx, ch_data[10*int'(arb_idx) +: 10], 2'b00};
  end

  assign half_end  = (hcnt_q == '0);
  assign frame_end = (state_q == S_SHIFT) && half_end && sclk_q && (bcnt_q == 4'd15);

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and pin/handshake outputs.
  always_comb begin
    state_d = state_q;
    ch_ack  = '0;
    cfg_ack = 1'b0;
    busy    = (state_q != S_IDLE);
    SYNC_b  = 1'b1;
    DIN     = 1'b0;
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
    LDAC_b  = (state_q != S_LDAC);
`else
    LDAC_b  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (cfg_req || arb_found) state_d = S_LOAD;
      S_LOAD: begin
        cfg_ack = gnt_cfg_q;
        ch_ack  = gnt_cfg_q ? 8'h00 : (8'h01 << gnt_idx_q);
        SYNC_b  = 1'b0;
        DIN     = sr_q[15];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        SYNC_b = 1'b0;
        DIN    = sr_q[15];
        if (frame_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
          if (ldac_pend_q && !cfg_req && (ch_req == 8'h00)) state_d = S_LDAC;
          else                                              state_d = S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
      S_LDAC: if (lcnt_q == '0) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign SCLK = sclk_q;

  // Datapath: frame capture, SCLK/bit timing, gap and pulse counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is
      // cleared on reset like every other register here.
      sclk_q    <= 1'b0;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      sr_q      <= '0;
      gcnt_q    <= '0;
      ptr_q     <= '0;
      gnt_cfg_q <= 1'b0;
      gnt_idx_q <= '0;
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
      ldac_pend_q <= 1'b0;
      lcnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_LOAD) begin
            if (cfg_req) begin
              gnt_cfg_q <= 1'b1;
              sr_q      <= orient(cfg_word);
            end else begin
              gnt_cfg_q <= 1'b0;
              gnt_idx_q <= arb_idx;
              ptr_q     <= arb_idx + 3'd1;
              sr_q      <= orient(chan_frame);
            end
            // The LOAD cycle is the first cycle of bit 0's low phase.
            hcnt_q <= HC_RELOAD;
            sclk_q <= 1'b0;
            bcnt_q <= '0;
          end
        end
        S_LOAD, S_SHIFT: begin
          if (half_end) begin
            hcnt_q <= HC_RELOAD;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bcnt_q == 4'd15) begin
                bcnt_q <= '0;
                gcnt_q <= GC_RELOAD;
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
                if (!gnt_cfg_q) ldac_pend_q <= 1'b1;
`endif
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
                sr_q   <= {sr_q[14:0], 1'b0};
              end
            end
          end else begin
            hcnt_q <= hcnt_q - HC_W'(1);
          end
        end
        S_GAP: begin
          if (gcnt_q != '0) gcnt_q <= gcnt_q - GC_W'(1);
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
          if (state_d == S_LDAC) begin
            lcnt_q      <= LC_RELOAD;
            ldac_pend_q <= 1'b0;
          end
`endif
        end
`ifdef DAC_AD5318_CTRL_LDAC_PULSE_EN
        S_LDAC: if (lcnt_q != '0) lcnt_q <= lcnt_q - LC_W'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule
